// File: rtl/huffman_table_loader_pkg.sv
// Shared state encoding and sizing helper for the Huffman table loader.
package huffman_table_loader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Bits needed to hold the value v, so a length field can encode 0..MAX_CODE_LENGTH.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/huffman_table_loader_addr_gen.sv
// Fill-slot address generator: slot index in the upper address bits, masked code in the lower len bits.
// Address and last flag are combinational from the registered slot count.
module table_fill_addr_gen #(
  parameter int MAX_CODE_LENGTH      = 9,
  parameter int LOG2_MAX_CODE_LENGTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            step,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] len,
  input  logic [MAX_CODE_LENGTH-1:0]      code,
  output logic [MAX_CODE_LENGTH-1:0]      addr,
  output logic                            last
);

  logic [MAX_CODE_LENGTH-1:0] count;
  logic [MAX_CODE_LENGTH-1:0] code_mask;
  logic [MAX_CODE_LENGTH-1:0] last_count;

  // len == MAX_CODE_LENGTH shifts every ones-bit out: full mask, single slot.
  assign code_mask  = ~({MAX_CODE_LENGTH{1'b1}} << len);
  assign last_count = {MAX_CODE_LENGTH{1'b1}} >> len;
  assign addr       = (count << len) | (code & code_mask);
  assign last       = (count == last_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      count <= count + MAX_CODE_LENGTH'(1);
    end
  end

endmodule

// File: rtl/huffman_table_loader.sv
// Expands canonical (code, len, symbol) entries into every owned decode-table slot, one write per cycle.
// Latency: entry accepted at edge N -> first registered table write visible after edge N+1; no bubble between entries.
// Backpressure: one pending slot; entry_full blocks pushes. HUFFMAN_TABLE_KRAFT_CHECK_EN enables the Kraft-sum check.
module huffman_table_loader
  import huffman_table_loader_pkg::*;
#(
  parameter int MAX_CODE_LENGTH      = 9,
  parameter int WIDTH_OUT            = 8,
  parameter int LOG2_MAX_CODE_LENGTH = log2(MAX_CODE_LENGTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            entry_push,
  input  logic [MAX_CODE_LENGTH-1:0]      entry_code,
  input  logic [LOG2_MAX_CODE_LENGTH-1:0] entry_len,
  input  logic [WIDTH_OUT-1:0]            entry_data,
  output logic                            entry_full,
  input  logic                            commit,
  output logic                            busy,
  output logic                            err,
  output logic                            table_complete,
  output logic                            table_push,
  output logic [MAX_CODE_LENGTH-1:0]      table_addr,
  output logic [LOG2_MAX_CODE_LENGTH-1:0] table_code_width,
  output logic [WIDTH_OUT-1:0]            table_data
);

  localparam logic [LOG2_MAX_CODE_LENGTH-1:0] LEN_MAX = LOG2_MAX_CODE_LENGTH'(MAX_CODE_LENGTH);

  typedef struct packed {
    logic [MAX_CODE_LENGTH-1:0]      code;
    logic [LOG2_MAX_CODE_LENGTH-1:0] len;
    logic [WIDTH_OUT-1:0]            data;
  } entry_t;

  fill_state_t                state, state_nxt;
  entry_t                     active, pending, in_entry;
  logic                       pending_valid;
  logic                       len_ok, take, last, emit;
  logic                       load_in, load_pend, to_pending;
  logic                       commit_req, do_commit;
  logic [MAX_CODE_LENGTH-1:0] fill_addr;

  assign in_entry   = '{code: entry_code, len: entry_len, data: entry_data};
  assign len_ok     = (entry_len != '0) && (entry_len <= LEN_MAX);
  assign take       = entry_push && !pending_valid && len_ok;
  assign emit       = (state == FILL);
  assign entry_full = pending_valid;
  assign busy       = (state == FILL) || pending_valid;
  // A commit seen while busy is held until the fill and any pending entry have drained.
  assign do_commit  = (commit || commit_req) && !busy;

  table_fill_addr_gen #(
    .MAX_CODE_LENGTH      (MAX_CODE_LENGTH),
    .LOG2_MAX_CODE_LENGTH (LOG2_MAX_CODE_LENGTH)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load_in || load_pend),
    .step (emit && !last),
    .len  (active.len),
    .code (active.code),
    .addr (fill_addr),
    .last (last)
  );

  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    to_pending = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          load_in   = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (last) begin
          if (pending_valid)  load_pend = 1'b1;
          else if (take)      load_in   = 1'b1;
          else                state_nxt = IDLE;
        end else if (take) begin
          to_pending = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      active           <= '0;
      pending          <= '0;
      pending_valid    <= 1'b0;
      err              <= 1'b0;
      commit_req       <= 1'b0;
      table_push       <= 1'b0;
      table_addr       <= '0;
      table_code_width <= '0;
      table_data       <= '0;
    end else begin
      state <= state_nxt;
      if (load_in)        active <= in_entry;
      else if (load_pend) active <= pending;
      if (to_pending) pending <= in_entry;
      if (load_pend)       pending_valid <= 1'b0;
      else if (to_pending) pending_valid <= 1'b1;
      if (entry_push && (pending_valid || !len_ok)) err <= 1'b1;
      if (do_commit)   commit_req <= 1'b0;
      else if (commit) commit_req <= 1'b1;
      table_push <= emit;
      if (emit) begin
        table_addr       <= fill_addr;
        table_code_width <= active.len;
        table_data       <= active.data;
      end
    end
  end

`ifdef HUFFMAN_TABLE_KRAFT_CHECK_EN
  localparam logic [MAX_CODE_LENGTH:0] KRAFT_FULL = {1'b1, {MAX_CODE_LENGTH{1'b0}}};

  logic [MAX_CODE_LENGTH:0] kraft_sum, kraft_add;

  // Each legal entry owns 2^(MAX-len) slots; a complete prefix code owns them all.
  assign kraft_add = take ? ({{MAX_CODE_LENGTH{1'b0}}, 1'b1} << (LEN_MAX - entry_len)) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kraft_sum      <= '0;
      table_complete <= 1'b0;
    end else if (do_commit) begin
      table_complete <= (kraft_sum == KRAFT_FULL);
      kraft_sum      <= kraft_add;
    end else begin
      kraft_sum <= kraft_sum + kraft_add;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      table_complete <= 1'b0;
    end else if (do_commit) begin
      table_complete <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_table_loader.sv
// Bench for huffman_table_loader: vector table, hand-written corner sequences, randomized entries vs. slot-expansion model.
module tb_huffman_table_loader;

  localparam int MAXL = 9;
  localparam int LW   = 4;
  localparam int WO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          entry_push;
  logic [8:0]    entry_code;
  logic [3:0]    entry_len;
  logic [7:0]    entry_data;
  logic          entry_full;
  logic          commit;
  logic          busy;
  logic          err;
  logic          table_complete;
  logic          table_push;
  logic [8:0]    table_addr;
  logic [3:0]    table_code_width;
  logic [7:0]    table_data;

  huffman_table_loader #(
    .MAX_CODE_LENGTH      (MAXL),
    .WIDTH_OUT            (WO),
    .LOG2_MAX_CODE_LENGTH (LW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .entry_push       (entry_push),
    .entry_code       (entry_code),
    .entry_len        (entry_len),
    .entry_data       (entry_data),
    .entry_full       (entry_full),
    .commit           (commit),
    .busy             (busy),
    .err              (err),
    .table_complete   (table_complete),
    .table_push       (table_push),
    .table_addr       (table_addr),
    .table_code_width (table_code_width),
    .table_data       (table_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] addr;
    logic [3:0] width;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int len;
    int code;
    int data;
    int n;
    int first;
    int last;
  } vec_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  logic [8:0] first_addr, last_addr;
  int         kraft = 0;
  logic       exp_err = 1'b0;
  vec_t       vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a legal entry owns every slot whose low len bits equal its code.
  task automatic model_push(input int len, input int code, input int data);
    if (len < 1 || len > MAXL) begin
      exp_err = 1'b1;
      return;
    end
    for (int f = 0; f < (1 << (MAXL - len)); f++) begin
      exp_q.push_back('{addr: 9'((f << len) | (code & ((1 << len) - 1))),
                        width: 4'(len), data: 8'(data)});
    end
    kraft += 1 << (MAXL - len);
  endtask

  // One clock; every table write observed is matched against the model queue.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (table_push) begin
      wr_count++;
      if (wr_count == 1) first_addr = table_addr;
      last_addr = table_addr;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h required no write", table_addr);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(table_addr), 32'(w.addr));
        check("wr_width", 32'(table_code_width), 32'(w.width));
        check("wr_data", 32'(table_data), 32'(w.data));
      end
    end
  endtask

  task automatic push_entry(input int len, input int code, input int data);
    int g;
    g = 0;
    while (entry_full && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) begin
      checks++;
      errors++;
      $display("FAIL push_wait actual entry_full=%0b required 0 within budget", entry_full);
    end
    entry_push = 1'b1;
    entry_len  = 4'(len);
    entry_code = 9'(code);
    entry_data = 8'(data);
    model_push(len, code, data);
    tick();
    entry_push = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || exp_q.size() != 0) && g < 3000) begin
      tick();
      g++;
    end
    if (g >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual busy=%0b outstanding=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    entry_push = 1'b0;
    commit     = 1'b0;
    #1;
    exp_q.delete();
    exp_err = 1'b0;
    kraft   = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic exp_complete();
`ifdef HUFFMAN_TABLE_KRAFT_CHECK_EN
    return (kraft == (1 << MAXL));
`else
    return 1'b1;
`endif
  endfunction

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    int rl;
    logic ec;
    rst        = 1'b0;
    entry_push = 1'b0;
    entry_code = '0;
    entry_len  = '0;
    entry_data = '0;
    commit     = 1'b0;

    vecs[0] = '{len: 9, code: 'h1A5, data: 'h41, n: 1,   first: 'h1A5, last: 'h1A5};
    vecs[1] = '{len: 1, code: 'h001, data: 'h07, n: 256, first: 'h001, last: 'h1FF};
    vecs[2] = '{len: 8, code: 'h083, data: 'h12, n: 2,   first: 'h083, last: 'h183};
    vecs[3] = '{len: 3, code: 'h1FD, data: 'h99, n: 64,  first: 'h005, last: 'h1FD};
    vecs[4] = '{len: 5, code: 'h00A, data: 'hC3, n: 16,  first: 'h00A, last: 'h1EA};
    vecs[5] = '{len: 2, code: 'h002, data: 'h5E, n: 128, first: 'h002, last: 'h1FE};

    // Reset state
    do_reset();
    check("rst_table_push", 32'(table_push), 32'(0));
    check("rst_table_addr", 32'(table_addr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_entry_full", 32'(entry_full), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_table_complete", 32'(table_complete), 32'(0));

    // Table-driven single entries
    for (int i = 0; i < 6; i++) begin
      wr_count = 0;
      push_entry(vecs[i].len, vecs[i].code, vecs[i].data);
      wait_idle();
      tick();
      check("vec_count", 32'(wr_count), 32'(vecs[i].n));
      check("vec_first", 32'(first_addr), 32'(vecs[i].first));
      check("vec_last", 32'(last_addr), 32'(vecs[i].last));
      check("vec_err", 32'(err), 32'(exp_err));
    end

    // Latency of a single-slot entry
    push_entry(9, 'h1A5, 'h41);
    check("lat_no_write_yet", 32'(table_push), 32'(0));
    check("lat_busy", 32'(busy), 32'(1));
    tick();
    check("lat_write", 32'(table_push), 32'(1));
    check("lat_addr", 32'(table_addr), 32'h1A5);
    check("lat_busy_after", 32'(busy), 32'(0));

    // Back-to-back len=8 entries: pending slot used, no bubble
    push_entry(8, 'h003, 'h21);
    entry_push = 1'b1;
    entry_len  = 4'd8;
    entry_code = 9'h083;
    entry_data = 8'h22;
    model_push(8, 'h083, 'h22);
    tick();
    entry_push = 1'b0;
    check("b2b_full", 32'(entry_full), 32'(1));
    check("b2b_a0", 32'(table_addr), 32'h003);
    tick();
    check("b2b_full_clear", 32'(entry_full), 32'(0));
    check("b2b_a1", 32'(table_addr), 32'h103);
    tick();
    check("b2b_b0_push", 32'(table_push), 32'(1));
    check("b2b_b0", 32'(table_addr), 32'h083);
    tick();
    check("b2b_b1_push", 32'(table_push), 32'(1));
    check("b2b_b1", 32'(table_addr), 32'h183);
    check("b2b_idle", 32'(busy), 32'(0));

    // Illegal lengths: dropped, sticky err
    do_reset();
    wr_count = 0;
    push_entry(0, 5, 1);
    repeat (3) tick();
    check("len0_err", 32'(err), 32'(exp_err));
    check("len0_busy", 32'(busy), 32'(0));
    push_entry(10, 7, 2);
    repeat (10) tick();
    check("len10_err", 32'(err), 32'(exp_err));
    check("illegal_no_writes", 32'(wr_count), 32'(0));
    do_reset();
    check("err_cleared", 32'(err), 32'(0));

    // Commit deferred while busy
    push_entry(1, 0, 'h10);
    push_entry(1, 1, 'h11);
    repeat (3) tick();
    pulse_commit();
    repeat (4) tick();
    check("commit_deferred", 32'(table_complete), 32'(0));
    wait_idle();
    tick();
    tick();
    ec = exp_complete();
    kraft = 0;
    check("commit_after_fill", 32'(table_complete), 32'(ec));

    // Kraft: 1/2 + 1/4 + 1/4 complete; without the last quarter incomplete
    push_entry(1, 0, 1);
    push_entry(2, 1, 2);
    push_entry(2, 3, 3);
    wait_idle();
    pulse_commit();
    tick();
    ec = exp_complete();
    kraft = 0;
    check("kraft_full", 32'(table_complete), 32'(ec));
    push_entry(1, 0, 1);
    push_entry(2, 1, 2);
    wait_idle();
    pulse_commit();
    tick();
    ec = exp_complete();
    kraft = 0;
    check("kraft_partial", 32'(table_complete), 32'(ec));

    // Reset in the middle of a fill
    do_reset();
    wr_count = 0;
    push_entry(1, 1, 'h33);
    rl = 0;
    while (wr_count < 10 && rl < 100) begin
      tick();
      rl++;
    end
    check("midfill_writes_seen", 32'(wr_count), 32'(10));
    rst = 1'b0;
    #1;
    check("midfill_push", 32'(table_push), 32'(0));
    check("midfill_busy", 32'(busy), 32'(0));
    check("midfill_full", 32'(entry_full), 32'(0));
    exp_q.delete();
    kraft = 0;
    tick();
    rst = 1'b1;
    wr_count = 0;
    push_entry(9, 'h055, 'h5A);
    wait_idle();
    tick();
    check("reload_count", 32'(wr_count), 32'(1));
    check("reload_addr", 32'(first_addr), 32'h055);

    // Randomized legal entries against the expansion model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) rl = $urandom_range(1, 2);
      else rl = $urandom_range(4, 9);
      push_entry(rl, $urandom_range(0, 511), $urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
    tick();
    check("rand_drained", 32'(exp_q.size()), 32'(0));
    check("rand_err", 32'(err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
